// File: rtl/obi_rr_mux.sv
// OBI bus types and the N:1 round-robin OBI mux. Granted port indices are kept
// in an in-order ID FIFO so each response is routed back to its requester.
package obi_pkg;

  typedef struct packed {
    logic UseRReady;
    logic Integrity;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0, Integrity: 1'b0};

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;

endpackage

module obi_rr_mux #(
  parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t   = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t   = obi_pkg::obi_rsp_t,
  parameter int unsigned       NumSbrPorts = 2,
  parameter int unsigned       NumMaxTrans = 2,
  parameter int unsigned       IdxWidth    = (NumSbrPorts > 1) ? $clog2(NumSbrPorts) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  obi_req_t                           sbr_ports_req_i [NumSbrPorts],
  output obi_rsp_t                           sbr_ports_rsp_o [NumSbrPorts],
  output obi_req_t                           mgr_port_req_o,
  input  obi_rsp_t                           mgr_port_rsp_i,
  output logic [$clog2(NumMaxTrans + 1)-1:0] in_flight_o,
  output logic                               busy_o
);

  localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);
  localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;

  if (ObiCfg.Integrity) begin : gen_bad_integrity
    $fatal(1, "obi_rr_mux: Integrity is not supported");
  end
  if (NumSbrPorts < 2) begin : gen_bad_ports
    $fatal(1, "obi_rr_mux: NumSbrPorts must be at least 2");
  end
  if (NumMaxTrans < 1) begin : gen_bad_trans
    $fatal(1, "obi_rr_mux: NumMaxTrans must be at least 1");
  end

  logic [IdxWidth-1:0] rr_ptr_q, lock_idx_q, sel_c, cand_c, head_c;
  logic                lock_q, found_c;
  logic [IdxWidth-1:0] fifo_q [NumMaxTrans];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                fifo_full_c, fifo_empty_c;
  logic                mgr_req_c, rready_c, push_c, pop_c;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (32'(p) == NumMaxTrans - 1) ? '0 : p + PtrWidth'(1);
  endfunction

  // A locked (ungranted) request keeps its port; otherwise search after rr_ptr.
  always_comb begin
    found_c = 1'b0;
    cand_c  = '0;
    sel_c   = rr_ptr_q;
    if (lock_q) begin
      sel_c = lock_idx_q;
    end else begin
      for (int unsigned k = 1; k <= NumSbrPorts; k++) begin
        cand_c = IdxWidth'((32'(rr_ptr_q) + k) % NumSbrPorts);
        if (!found_c && sbr_ports_req_i[cand_c].req) begin
          found_c = 1'b1;
          sel_c   = cand_c;
        end
      end
    end
  end

  assign fifo_full_c  = (cnt_q == CntWidth'(NumMaxTrans));
  assign fifo_empty_c = (cnt_q == '0);
  assign head_c       = fifo_q[rd_ptr_q];

  // Full blocks new requests even when a pop lands in the same cycle.
  assign mgr_req_c = ~rst_i & sbr_ports_req_i[sel_c].req & ~fifo_full_c;
  assign rready_c  = sbr_ports_req_i[head_c].rready | ~ObiCfg.UseRReady;
  assign push_c    = mgr_req_c & mgr_port_rsp_i.gnt;
  assign pop_c     = ~rst_i & ~fifo_empty_c & mgr_port_rsp_i.rvalid & rready_c;

  always_comb begin
    mgr_port_req_o = '0;
    if (!rst_i) begin
      mgr_port_req_o.a      = sbr_ports_req_i[sel_c].a;
      mgr_port_req_o.req    = mgr_req_c;
      mgr_port_req_o.rready = rready_c;
    end
  end

  // Response data is broadcast; only the FIFO head sees rvalid.
  always_comb begin
    for (int unsigned i = 0; i < NumSbrPorts; i++) begin
      sbr_ports_rsp_o[i]        = '0;
      sbr_ports_rsp_o[i].r      = mgr_port_rsp_i.r;
      sbr_ports_rsp_o[i].gnt    = push_c && (sel_c == IdxWidth'(i));
      sbr_ports_rsp_o[i].rvalid = ~rst_i && ~fifo_empty_c && mgr_port_rsp_i.rvalid &&
                                  (head_c == IdxWidth'(i));
    end
  end

  assign in_flight_o = rst_i ? '0 : cnt_q;
  assign busy_o      = ~rst_i & (mgr_req_c | ~fifo_empty_c);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= IdxWidth'(NumSbrPorts - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < NumMaxTrans; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= sel_c;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        rr_ptr_q         <= sel_c;
        lock_q           <= 1'b0;
      end else if (mgr_req_c) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_c;
      end
      if (pop_c) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_c && !pop_c) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end else if (!push_c && pop_c) begin
        cnt_q <= cnt_q - CntWidth'(1);
      end
    end
  end

  // A response with no outstanding ID is a manager protocol error.
  rvalid_while_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mgr_port_rsp_i.rvalid && fifo_empty_c));

endmodule

// File: tb/tb_obi_rr_mux.sv
// Directed bench for obi_rr_mux (3 ports, depth 3, rready honoured) checked
// against a queue-based reference model plus a hand-written grant order.
module tb_obi_rr_mux;
  import obi_pkg::*;

  localparam int unsigned NP   = 3;
  localparam int unsigned NT   = 3;
  localparam int unsigned NExp = 27;
  localparam obi_cfg_t    Cfg  = '{UseRReady: 1'b1, Integrity: 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  obi_req_t   sreq [NP];
  obi_rsp_t   srsp [NP];
  obi_req_t   mreq;
  obi_rsp_t   mrsp;
  logic [1:0] in_flight;
  logic       busy;

  always #5 clk = ~clk;

  obi_rr_mux #(
    .ObiCfg     (Cfg),
    .obi_req_t  (obi_req_t),
    .obi_rsp_t  (obi_rsp_t),
    .NumSbrPorts(NP),
    .NumMaxTrans(NT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sbr_ports_req_i(sreq),
    .sbr_ports_rsp_o(srsp),
    .mgr_port_req_o (mreq),
    .mgr_port_rsp_i (mrsp),
    .in_flight_o    (in_flight),
    .busy_o         (busy)
  );

  // Hand-computed grant order over all scenarios.
  int exp_order [NExp] = '{0, 1, 2, 0, 1, 2,
                           1, 0,
                           1, 2, 0, 1,
                           2, 0,
                           1, 2, 0,
                           1, 2, 0, 1, 2, 0, 1, 2, 0, 1};

  // Written by the stimulus process only.
  logic pin_if_en = 1'b0, pin_req_en = 1'b0, pin_req = 1'b0, fin = 1'b0;
  int   pin_if = 0;

  // Written by the compare process only.
  int n_run = 0, n_fail = 0, gidx = 0;
  int q[$];
  int last = NP - 1;
  int pend = -1;
  bit fin_done = 1'b0;

  function automatic void check(input string name, input logic [95:0] got,
                                input logic [95:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: outstanding IDs are a plain queue, arbitration is a
  // rotating search after the last winner, a stalled request is remembered.
  always @(negedge clk) begin
    int sel;
    bit ereq, hs, pop;
    if (rst) begin
      check("rst_mgr_req", 96'(mreq.req), 96'(1'b0));
      check("rst_busy", 96'(busy), 96'(1'b0));
      check("rst_in_flight", 96'(in_flight), 96'(0));
      for (int i = 0; i < NP; i++) begin
        check("rst_gnt", 96'(srsp[i].gnt), 96'(1'b0));
        check("rst_rvalid", 96'(srsp[i].rvalid), 96'(1'b0));
      end
      q.delete();
      last = NP - 1;
      pend = -1;
    end else begin
      sel = -1;
      if (pend >= 0) sel = pend;
      else begin
        for (int k = 1; k <= NP; k++) begin
          if (sel < 0 && sreq[(last + k) % NP].req) sel = (last + k) % NP;
        end
      end
      ereq = (sel >= 0) && sreq[sel].req && (q.size() < NT);
      hs   = ereq && mrsp.gnt;

      check("mgr_req", 96'(mreq.req), 96'(ereq));
      if (ereq) check("mgr_a", 96'(mreq.a), 96'(sreq[sel].a));
      if (q.size() > 0) check("mgr_rready", 96'(mreq.rready), 96'(sreq[q[0]].rready));
      check("in_flight", 96'(in_flight), 96'(q.size()));
      check("busy", 96'(busy), 96'(ereq || q.size() > 0));
      for (int i = 0; i < NP; i++) begin
        check("sbr_gnt", 96'(srsp[i].gnt), 96'(hs && i == sel));
        check("sbr_rvalid", 96'(srsp[i].rvalid),
              96'(q.size() > 0 && mrsp.rvalid && q[0] == i));
        check("sbr_r", 96'(srsp[i].r), 96'(mrsp.r));
      end
      if (pin_if_en) check("pin_in_flight", 96'(in_flight), 96'(pin_if));
      if (pin_req_en) check("pin_mgr_req", 96'(mreq.req), 96'(pin_req));

      for (int i = 0; i < NP; i++) begin
        if (srsp[i].gnt) begin
          if (gidx < NExp) check("gnt_order", 96'(i), 96'(exp_order[gidx]));
          else check("gnt_extra", 96'(i), 96'(-1));
          gidx++;
        end
      end

      pop = (q.size() > 0) && mrsp.rvalid && sreq[q[0]].rready;
      if (pop) void'(q.pop_front());
      if (hs) begin
        q.push_back(sel);
        last = sel;
        pend = -1;
      end else if (ereq) begin
        pend = sel;
      end
    end
    if (fin && !fin_done) begin
      check("gnt_count", 96'(gidx), 96'(NExp));
      fin_done = 1'b1;
    end
  end

  int rd_seq = 0;

  task automatic step();
    @(posedge clk);
    #1;
    pin_if_en  = 1'b0;
    pin_req_en = 1'b0;
  endtask

  // One cycle with request vector r (bit i = port i), manager gnt and rvalid.
  task automatic cyc(input logic [2:0] r, input logic g, input logic v);
    for (int i = 0; i < NP; i++) sreq[i].req = r[i];
    mrsp.gnt     = g;
    mrsp.rvalid  = v;
    mrsp.r.rdata = 32'hA000 + 32'(rd_seq);
    mrsp.r.err   = rd_seq[0];
    rd_seq++;
    step();
  endtask

  task automatic pins(input int f, input logic rq);
    pin_if_en = 1'b1;
    pin_if    = f;
    if (rq !== 1'bx) begin
      pin_req_en = 1'b1;
      pin_req    = rq;
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      sreq[i]         = '0;
      sreq[i].a.addr  = 32'h1000 * 32'(i + 1);
      sreq[i].a.we    = i[0];
      sreq[i].a.be    = 4'hF;
      sreq[i].a.wdata = 32'hD0 + 32'(i);
      sreq[i].rready  = 1'b1;
    end
    mrsp = '0;
    rst  = 1'b1;
    step();
    step();
    rst = 1'b0;

    // All ports streaming, response one cycle after each grant.
    for (int c = 0; c < 8; c++) begin
      if (c == 3) pins(1, 1'b1);
      cyc((c < 6) ? 3'b111 : 3'b000, c < 6, c >= 1 && c <= 6);
    end

    // Stalled port 1 stays locked while port 0 joins.
    cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b011, 1'b0, 1'b0);
    pins(0, 1'b1);
    cyc(3'b011, 1'b0, 1'b0);
    cyc(3'b011, 1'b1, 1'b0);
    cyc(3'b001, 1'b1, 1'b1);
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);

    // Fill the ID FIFO, then a pop frees a slot only for the next cycle.
    repeat (3) cyc(3'b111, 1'b1, 1'b0);
    pins(3, 1'b0);
    cyc(3'b111, 1'b1, 1'b0);
    pins(3, 1'b0);
    cyc(3'b111, 1'b1, 1'b1);
    pins(2, 1'b1);
    cyc(3'b111, 1'b1, 1'b0);
    repeat (3) cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);

    // Head port 2 holds rready low, response waits.
    cyc(3'b100, 1'b1, 1'b0);
    cyc(3'b001, 1'b1, 1'b0);
    sreq[2].rready = 1'b0;
    pins(2, 1'b0);
    cyc(3'b000, 1'b0, 1'b1);
    pins(2, 1'b0);
    cyc(3'b000, 1'b0, 1'b1);
    sreq[2].rready = 1'b1;
    cyc(3'b000, 1'b0, 1'b1);
    pins(1, 1'b0);
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);

    // Reset with two IDs outstanding and a locked request.
    cyc(3'b110, 1'b1, 1'b0);
    cyc(3'b110, 1'b1, 1'b0);
    pins(2, 1'b1);
    cyc(3'b111, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(3'b111, 1'b1, 1'b0);
    cyc(3'b111, 1'b1, 1'b0);
    rst = 1'b0;
    pins(0, 1'b1);
    cyc(3'b111, 1'b1, 1'b0);
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0);

    // Ten back-to-back transactions wrapping the depth-3 FIFO.
    for (int t = 0; t < 14; t++) begin
      if (t == 3) pins(3, 1'b0);
      if (t == 13) pins(0, 1'b0);
      cyc((t <= 10) ? 3'b111 : 3'b000, t <= 10, t >= 3 && t <= 12);
    end

    fin = 1'b1;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
